// File: rtl/bcd_decoder_if.sv
// Handshake bundle for the BCD-to-binary converter: one valid/ready
// channel carrying packed BCD in, one carrying the binary result out.
interface bcd_decoder_if #(
    parameter int N_DIGITS  = 4,
    parameter int BIN_WIDTH = $clog2(10**N_DIGITS)
);
    logic                    in_valid;
    logic                    in_ready;
    logic [4*N_DIGITS-1:0]   in_bcd;
    logic                    out_valid;
    logic                    out_ready;
    logic [BIN_WIDTH-1:0]    out_bin;
    logic                    out_err;

    // Producer of BCD words and consumer of results.
    modport master (
        output in_valid, in_bcd, out_ready,
        input  in_ready, out_valid, out_bin, out_err
    );

    // The converter itself.
    modport slave (
        input  in_valid, in_bcd, out_ready,
        output in_ready, out_valid, out_bin, out_err
    );
endinterface

// File: rtl/bcd_decoder.sv
// Sequential multi-digit BCD-to-binary converter using reverse double-dabble.
// A packed BCD word is loaded into the top half of a {bcd, bin} working
// register; each cycle the register shifts right by one and any BCD digit
// that reads >= 8 afterwards is reduced by 3. After 4*N_DIGITS shifts the
// bin half holds the binary value. Digits above 9 still run the full
// conversion, but the result is forced to zero with out_err set.
module bcd_decoder #(
    parameter int N_DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    bcd_decoder_if.slave      bus
);
    localparam int BIN_WIDTH = $clog2(10**N_DIGITS);
    localparam int BCD_W     = 4 * N_DIGITS;
    localparam int WORK_W    = 8 * N_DIGITS;
    localparam int CNT_W     = $clog2(BCD_W + 1);

    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BCD_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // True when any 4-bit digit of the packed word is outside 0..9.
    function automatic logic any_digit_invalid(input logic [BCD_W-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            bad = bad | (bcd[4*i +: 4] > 4'd9);
        end
        return bad;
    endfunction

    // One reverse double-dabble step: shift right, then correct every BCD
    // digit independently (digit corrections never interact).
    function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] s;
        s = w >> 1;
        for (int i = 0; i < N_DIGITS; i++) begin
            s[BCD_W + 4*i +: 4] = (s[BCD_W + 4*i +: 4] >= 4'd8) ?
                                  (s[BCD_W + 4*i +: 4] - 4'd3) :
                                   s[BCD_W + 4*i +: 4];
        end
        return s;
    endfunction

    logic [1:0]           state_r;
    logic [WORK_W-1:0]    work_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 err_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [BIN_WIDTH-1:0] out_bin_r;
    logic                 out_err_r;

    logic [WORK_W-1:0]    work_next_s;
    logic                 accept_s;
    logic                 release_s;

    // Next working-register value and the two handshake events.
    always_comb begin
        work_next_s = dabble_step(work_r);
        accept_s    = bus.in_valid & in_ready_r;
        release_s   = out_valid_r & bus.out_ready;
    end

    // Control FSM, datapath and registered outputs; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            work_r      <= {WORK_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_bin_r   <= {BIN_WIDTH{1'b0}};
            out_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        work_r     <= {bus.in_bcd, {BCD_W{1'b0}}};
                        err_r      <= any_digit_invalid(bus.in_bcd);
                        cnt_r      <= {CNT_W{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    work_r <= work_next_s;
                    cnt_r  <= cnt_r + CNT_W'(1);
                    // The final shift lands directly in the output register so
                    // out_valid rises exactly 4*N_DIGITS edges after accept.
                    if (cnt_r == LAST_SHIFT) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        out_bin_r   <= err_r ? {BIN_WIDTH{1'b0}} :
                                               work_next_s[BIN_WIDTH-1:0];
                        out_err_r   <= err_r;
                    end
                end
                ST_DONE: begin
                    if (release_s) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_bin   = out_bin_r;
    assign bus.out_err   = out_err_r;

endmodule
